// File: rtl/mpsoc_msi_wb_arbiter_rr.sv
// Wishbone B3 N-master to 1-slave arbiter: round-robin grant, cycle-level bus
// locking by the owner's cyc, and a watchdog that turns a hung access into err.
module mpsoc_msi_wb_arbiter_rr #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master side
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    // slave side
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    // status
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        state_o
);

    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = DW / 8;

    localparam logic [OW-1:0] LAST_IDX = OW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, last_owner, rr_pick;
    logic            rr_found;
    logic [CW-1:0]   to_cnt;
    logic            owner_cyc, owner_stb, slave_term, expire;

    assign owner_cyc  = wbm_cyc_i[owner];
    assign owner_stb  = wbm_stb_i[owner];
    assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign state_o    = (state == GRANT);
    assign wbm_dat_o  = {NUM_MASTERS{wbs_dat_i}};

    // Round-robin search starting just above the previous owner.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!rr_found && wbm_cyc_i[(int'(last_owner) + i) % NUM_MASTERS]) begin
                rr_found = 1'b1;
                rr_pick  = OW'((int'(last_owner) + i) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_found)   state_nxt = GRANT;
            GRANT:   if (!owner_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_IDX;
            grant_o    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && rr_found) begin
                owner   <= rr_pick;
                grant_o <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << rr_pick;
            end else if (state == GRANT && !owner_cyc) begin
                last_owner <= owner;
                grant_o    <= '0;
            end
        end
    end

    // A slave termination in the expiry cycle takes precedence over the forced err.
    assign expire = (TIMEOUT > 0) && (state == GRANT) && owner_stb && !slave_term
                    && (to_cnt == TO_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (state != GRANT || !owner_stb || slave_term || expire) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Handshake: a beat is offered while cyc&stb are high and completes in the
    // cycle the slave raises ack/err/rty; the owner keeps the bus while cyc is high.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (state == GRANT) begin
            wbs_adr_o = wbm_adr_i[int'(owner)*AW +: AW];
            wbs_dat_o = wbm_dat_i[int'(owner)*DW +: DW];
            wbs_sel_o = wbm_sel_i[int'(owner)*SW +: SW];
            wbs_we_o  = wbm_we_i[owner];
            wbs_cyc_o = owner_cyc;
            wbs_stb_o = owner_stb & ~expire;
            wbs_cti_o = wbm_cti_i[int'(owner)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(owner)*2 +: 2];
            wbm_ack_o[owner] = wbs_ack_i;
            wbm_err_o[owner] = wbs_err_i | expire;
            wbm_rty_o[owner] = wbs_rty_i;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter_rr.sv
// Directed bench for the round-robin Wishbone arbiter: expected terminations are
// queued by the stimulus and popped by a monitor whenever a master is terminated.
`timescale 1ns/1ps
module tb_mpsoc_msi_wb_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              wb_clk_i, wb_rst_i;
    logic [N*AW-1:0]   wbm_adr_i;
    logic [N*DW-1:0]   wbm_dat_i;
    logic [N*4-1:0]    wbm_sel_i;
    logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [N*3-1:0]    wbm_cti_i;
    logic [N*2-1:0]    wbm_bte_i;
    logic [N*DW-1:0]   wbm_dat_o;
    logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [3:0]        wbs_sel_o;
    logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]        wbs_cti_o;
    logic [1:0]        wbs_bte_o;
    logic [DW-1:0]     wbs_dat_i;
    logic              wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [N-1:0]      grant_o;
    logic              state_o;

    mpsoc_msi_wb_arbiter_rr #(
        .AW(AW), .DW(DW), .NUM_MASTERS(N), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i),
        .grant_o(grant_o), .state_o(state_o)
    );

    typedef struct packed {
        logic [N-1:0]   grant;
        logic [N-1:0]   ack;
        logic [N-1:0]   err;
        logic [31:0]    adr;
        logic [31:0]    dat;
        logic [3:0]     sel;
        logic           we;
        logic           stb;
        logic [2:0]     cti;
        logic [N*DW-1:0] rdat;
        logic [7:0]     lat;
    } ev_t;

    localparam logic [31:0]   SLV_RDATA = 32'h5A5A_1234;
    localparam logic [N*DW-1:0] RDAT_ALL = 96'h5A5A1234_5A5A1234_5A5A1234;

    ev_t  exp_q[$];
    ev_t  act_ev, exp_ev;
    int   checks = 0;
    int   failures = 0;
    int   ack_delay = 0;
    int   stall_n = 0;
    int   beat_cyc = 0;
    logic [N-1:0] prev_grant = '0;

    // clock / reset
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: acks after ack_delay stalled cycles of an active cycle.
    always @(posedge wb_clk_i) begin
        #2;
        if (wbs_cyc_o && !wb_rst_i) begin
            if (stall_n >= ack_delay) begin
                wbs_ack_i = 1'b1;
                stall_n   = 0;
            end else begin
                wbs_ack_i = 1'b0;
                stall_n++;
            end
        end else begin
            wbs_ack_i = 1'b0;
            stall_n   = 0;
        end
    end

    // Monitor / scoreboard
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            beat_cyc   = 0;
            prev_grant = '0;
        end else begin
            if (grant_o != '0 && grant_o != prev_grant) begin
                checks++;
                if (prev_grant != '0 || !$onehot(grant_o)) begin
                    failures++;
                    $display("FAIL grant_gap: grant=%b prev=%b, required one-hot after an idle cycle",
                             grant_o, prev_grant);
                end
            end
            prev_grant = grant_o;
            if (wbs_cyc_o) beat_cyc++;
            else beat_cyc = 0;
            if (|{wbm_ack_o, wbm_err_o, wbm_rty_o}) begin
                act_ev = '{grant: grant_o, ack: wbm_ack_o, err: wbm_err_o | wbm_rty_o,
                           adr: wbs_adr_o, dat: wbs_dat_o, sel: wbs_sel_o, we: wbs_we_o,
                           stb: wbs_stb_o, cti: wbs_cti_o, rdat: wbm_dat_o,
                           lat: 8'(beat_cyc)};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_term: act=%p, required no termination", act_ev);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (act_ev !== exp_ev) begin
                        failures++;
                        $display("FAIL term_event: act=%p exp=%p", act_ev, exp_ev);
                    end
                end
                beat_cyc = 0;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] grant, input logic [N-1:0] ack,
                            input logic [N-1:0] err, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input logic we,
                            input logic stb, input logic [2:0] cti, input logic [7:0] lat);
        ev_t e;
        e = '{grant: grant, ack: ack, err: err, adr: adr, dat: dat, sel: sel, we: we,
              stb: stb, cti: cti, rdat: RDAT_ALL, lat: lat};
        exp_q.push_back(e);
    endtask

    task automatic wait_term(input int m);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge wb_clk_i);
            if (wbm_ack_o[m] | wbm_err_o[m] | wbm_rty_o[m]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_term: master %0d had no termination within 100 cycles", m);
        end
    endtask

    // Driver: one master cycle of 'beats' beats; called at posedge+1.
    task automatic master_xfer(input int m, input logic [31:0] adr0, input logic [31:0] dat0,
                               input logic [3:0] sel, input logic we, input int beats);
        wbm_cyc_i[m] = 1'b1;
        wbm_stb_i[m] = 1'b1;
        wbm_we_i[m]  = we;
        wbm_sel_i[m*4 +: 4] = sel;
        for (int b = 0; b < beats; b++) begin
            wbm_adr_i[m*AW +: AW] = adr0 + 32'(4 * b);
            wbm_dat_i[m*DW +: DW] = dat0 + 32'(b);
            wbm_cti_i[m*3 +: 3]   = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
            wait_term(m);
            @(posedge wb_clk_i); #1;
        end
        wbm_cyc_i[m] = 1'b0;
        wbm_stb_i[m] = 1'b0;
        wbm_we_i[m]  = 1'b0;
        wbm_cti_i[m*3 +: 3]   = 3'b000;
        wbm_adr_i[m*AW +: AW] = '0;
        wbm_dat_i[m*DW +: DW] = '0;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
        wbm_we_i  = '0; wbm_cyc_i = '0; wbm_stb_i = '0;
        wbm_cti_i = '0; wbm_bte_i = '0;
        wbs_dat_i = SLV_RDATA;
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;

        // reset state
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_grant", 128'(grant_o), 128'(0));
        check("rst_cyc_stb", 128'({wbs_cyc_o, wbs_stb_o}), 128'(0));
        check("rst_wbs_req", 128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o}), 128'(0));
        check("rst_terms", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'(0));
        check("rst_state", 128'(state_o), 128'(0));
        check("rst_rdata", 128'(wbm_dat_o), 128'(RDAT_ALL));
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        // three simultaneous requesters: order 0, 1, 2
        push_exp(3'b001, 3'b001, 3'b000, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd1);
        push_exp(3'b010, 3'b010, 3'b000, 32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd1);
        push_exp(3'b100, 3'b100, 3'b000, 32'h30, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd1);
        fork
            master_xfer(0, 32'h10, 32'h0, 4'hF, 1'b0, 1);
            master_xfer(1, 32'h20, 32'h0, 4'hF, 1'b0, 1);
            master_xfer(2, 32'h30, 32'h0, 4'hF, 1'b0, 1);
        join
        repeat (2) @(posedge wb_clk_i); #1;

        // master 0 write, one cycle grant latency
        push_exp(3'b001, 3'b001, 3'b000, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 3'b000, 8'd1);
        fork
            master_xfer(0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 1'b1, 1);
            begin
                @(negedge wb_clk_i);
                check("lat_idle_cyc", 128'(wbs_cyc_o), 128'(0));
                @(negedge wb_clk_i);
                check("lat_grant_req", 128'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o}),
                      128'({3'b111, 32'h0000_0040}));
            end
        join
        repeat (2) @(posedge wb_clk_i); #1;

        // master 1 incrementing burst locks out master 0
        push_exp(3'b010, 3'b010, 3'b000, 32'h100, 32'h1000, 4'hF, 1'b1, 1'b1, 3'b010, 8'd1);
        push_exp(3'b010, 3'b010, 3'b000, 32'h104, 32'h1001, 4'hF, 1'b1, 1'b1, 3'b010, 8'd1);
        push_exp(3'b010, 3'b010, 3'b000, 32'h108, 32'h1002, 4'hF, 1'b1, 1'b1, 3'b010, 8'd1);
        push_exp(3'b010, 3'b010, 3'b000, 32'h10C, 32'h1003, 4'hF, 1'b1, 1'b1, 3'b111, 8'd1);
        push_exp(3'b001, 3'b001, 3'b000, 32'h80,  32'h0,    4'h3, 1'b0, 1'b1, 3'b000, 8'd1);
        fork
            master_xfer(1, 32'h100, 32'h1000, 4'hF, 1'b1, 4);
            begin
                repeat (2) @(posedge wb_clk_i); #1;
                master_xfer(0, 32'h80, 32'h0, 4'h3, 1'b0, 1);
            end
            begin
                repeat (3) @(negedge wb_clk_i);
                check("burst_lock_grant", 128'(grant_o), 128'(3'b010));
            end
        join
        repeat (2) @(posedge wb_clk_i); #1;

        // watchdog expiry on a master 2 read
        ack_delay = 1000;
        push_exp(3'b100, 3'b000, 3'b100, 32'h300, 32'h0, 4'hF, 1'b0, 1'b0, 3'b000, 8'd8);
        master_xfer(2, 32'h300, 32'h0, 4'hF, 1'b0, 1);
        repeat (2) @(posedge wb_clk_i); #1;

        // ack arriving in the expiry cycle wins
        ack_delay = 7;
        push_exp(3'b010, 3'b010, 3'b000, 32'h400, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd8);
        master_xfer(1, 32'h400, 32'h0, 4'hF, 1'b0, 1);
        ack_delay = 0;
        repeat (2) @(posedge wb_clk_i); #1;

        // reset in the middle of a master 2 burst
        push_exp(3'b100, 3'b100, 3'b000, 32'h500, 32'h0, 4'hF, 1'b0, 1'b1, 3'b010, 8'd1);
        push_exp(3'b100, 3'b100, 3'b000, 32'h504, 32'h0, 4'hF, 1'b0, 1'b1, 3'b010, 8'd1);
        wbm_cyc_i[2] = 1'b1;
        wbm_stb_i[2] = 1'b1;
        wbm_sel_i[11:8] = 4'hF;
        wbm_cti_i[8:6]  = 3'b010;
        wbm_adr_i[95:64] = 32'h500;
        wait_term(2);
        @(posedge wb_clk_i); #1;
        wbm_adr_i[95:64] = 32'h504;
        wait_term(2);
        @(posedge wb_clk_i); #1;
        wbm_adr_i[95:64] = 32'h508;
        wb_rst_i = 1'b1;
        #2;
        check("midrst_cyc_stb", 128'({wbs_cyc_o, wbs_stb_o}), 128'(0));
        check("midrst_grant", 128'(grant_o), 128'(0));
        check("midrst_state", 128'(state_o), 128'(0));
        wbm_cyc_i[2] = 1'b0;
        wbm_stb_i[2] = 1'b0;
        wbm_cti_i[8:6]  = 3'b000;
        wbm_adr_i[95:64] = '0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // arbitration restarts from master 0
        push_exp(3'b001, 3'b001, 3'b000, 32'h600, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd1);
        push_exp(3'b100, 3'b100, 3'b000, 32'h700, 32'h0, 4'hF, 1'b0, 1'b1, 3'b000, 8'd1);
        fork
            master_xfer(0, 32'h600, 32'h0, 4'hF, 1'b0, 1);
            master_xfer(2, 32'h700, 32'h0, 4'hF, 1'b0, 1);
        join

        repeat (3) @(posedge wb_clk_i);
        check("exp_q_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL sim_time_limit: simulation did not finish within 200000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
